// File: rtl/bus_pkg.sv
// Shared definitions for the two-master serial bus arbiter.
package bus_pkg;

  // Transaction-tracking FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WDATA   = 3'd2,
    ST_RDATA   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Master identifiers; also the value driven on the bus mux select.
  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  // Default serial frame geometry.
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TIMEOUT    = 255;

  // Larger of two integers, used to size the shared bit counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the
// master that did not own the bus last.
module rr_arbiter_2
  import bus_pkg::*;
(
  input  logic i_req1,
  input  logic i_req2,
  input  logic i_last,
  output logic o_valid,
  output logic o_winner
);

  // Combinational winner selection.
  always_comb begin
    o_valid  = i_req1 | i_req2;
    o_winner = M1;
    if (i_req1 && i_req2) begin
      o_winner = ~i_last;
    end else if (i_req2) begin
      o_winner = M2;
    end else begin
      o_winner = M1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serial bus arbiter: grants the shared bus to one of two masters, follows
// the transaction bit by bit and releases the grant on completion, on an
// early request drop, or on an idle timeout.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_breq,
  input  logic m2_breq,
  output logic m1_bgrant,
  output logic m2_bgrant,
  input  logic m1_mvalid,
  input  logic m2_mvalid,
  input  logic m1_mode,
  input  logic m2_mode,
  input  logic svalid,
  output logic msel,
  output logic busy,
  output logic timeout
);

  localparam int BW = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  logic            r_owner;
  logic            r_last_grant;
  logic            r_mode;
  logic [BW-1:0]   r_bit_cnt;
  logic [IW-1:0]   r_idle_cnt;
  logic            r_m1_bgrant;
  logic            r_m2_bgrant;
  logic            r_busy;
  logic            r_timeout;

  state_t          w_state_nxt;
  logic            w_owner_nxt;
  logic            w_last_nxt;
  logic            w_mode_nxt;
  logic [BW-1:0]   w_bit_nxt;
  logic [IW-1:0]   w_idle_nxt;
  logic            w_timeout_nxt;
  logic            w_grant_nxt;

  logic            w_req_any;
  logic            w_winner;
  logic            w_own_mvalid;
  logic            w_own_breq;
  logic            w_own_mode;
  logic            w_mode_eff;
  logic            w_data_bit;
  logic            w_idle_expired;

  rr_arbiter_2 u_rr (
    .i_req1   (m1_breq),
    .i_req2   (m2_breq),
    .i_last   (r_last_grant),
    .o_valid  (w_req_any),
    .o_winner (w_winner)
  );

  // Only the owning master's serial signals are observed.
  assign w_own_mvalid   = (r_owner == M2) ? m2_mvalid : m1_mvalid;
  assign w_own_breq     = (r_owner == M2) ? m2_breq   : m1_breq;
  assign w_own_mode     = (r_owner == M2) ? m2_mode   : m1_mode;
  // Mode comes from the live input on the first address bit, else the latch.
  assign w_mode_eff     = (r_bit_cnt == {BW{1'b0}}) ? w_own_mode : r_mode;
  assign w_data_bit     = (r_state == ST_WDATA) ? w_own_mvalid : svalid;
  assign w_idle_expired = (r_idle_cnt == IW'(TIMEOUT - 1));

  // Next-state, counter and pulse logic for the transaction tracker.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last_grant;
    w_mode_nxt    = r_mode;
    w_bit_nxt     = r_bit_cnt;
    w_idle_nxt    = r_idle_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_bit_nxt  = {BW{1'b0}};
        w_idle_nxt = {IW{1'b0}};
        if (w_req_any) begin
          w_state_nxt = ST_ADDR;
          w_owner_nxt = w_winner;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (w_own_mvalid) begin
          w_idle_nxt = {IW{1'b0}};
          w_mode_nxt = w_mode_eff;
          if (r_bit_cnt == BW'(ADDR_WIDTH - 1)) begin
            w_bit_nxt   = {BW{1'b0}};
            w_state_nxt = w_mode_eff ? ST_WDATA : ST_RDATA;
          end else begin
            w_bit_nxt = r_bit_cnt + BW'(1);
          end
        end else if (r_bit_cnt == {BW{1'b0}}) begin
          // Before the first bit the request may still be withdrawn.
          if (!w_own_breq) begin
            w_state_nxt = ST_RELEASE;
          end else begin
            w_state_nxt = ST_ADDR;
          end
        end else if (w_idle_expired) begin
          w_state_nxt   = ST_RELEASE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_idle_nxt = r_idle_cnt + IW'(1);
        end
      end
      ST_WDATA, ST_RDATA: begin
        if (w_data_bit) begin
          w_idle_nxt = {IW{1'b0}};
          if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
            w_bit_nxt   = {BW{1'b0}};
            w_state_nxt = ST_RELEASE;
          end else begin
            w_bit_nxt = r_bit_cnt + BW'(1);
          end
        end else if (w_idle_expired) begin
          w_state_nxt   = ST_RELEASE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_idle_nxt = r_idle_cnt + IW'(1);
        end
      end
      ST_RELEASE: begin
        w_last_nxt  = r_owner;
        w_bit_nxt   = {BW{1'b0}};
        w_idle_nxt  = {IW{1'b0}};
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bit_nxt   = {BW{1'b0}};
        w_idle_nxt  = {IW{1'b0}};
      end
    endcase
  end

  assign w_grant_nxt = (w_state_nxt == ST_ADDR) || (w_state_nxt == ST_WDATA) ||
                       (w_state_nxt == ST_RDATA);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= M1;
      r_last_grant <= M2;
      r_mode       <= 1'b0;
      r_bit_cnt    <= {BW{1'b0}};
      r_idle_cnt   <= {IW{1'b0}};
      r_m1_bgrant  <= 1'b0;
      r_m2_bgrant  <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_nxt;
      r_mode       <= w_mode_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_idle_cnt   <= w_idle_nxt;
      r_m1_bgrant  <= w_grant_nxt && (w_owner_nxt == M1);
      r_m2_bgrant  <= w_grant_nxt && (w_owner_nxt == M2);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign m1_bgrant = r_m1_bgrant;
  assign m2_bgrant = r_m2_bgrant;
  assign msel      = r_owner;
  assign busy      = r_busy;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m1_breq = 1'b0, m2_breq = 1'b0;
  logic m1_mvalid = 1'b0, m2_mvalid = 1'b0;
  logic m1_mode = 1'b0, m2_mode = 1'b0;
  logic svalid = 1'b0;
  logic m1_bgrant, m2_bgrant, msel, busy, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m1_breq   (m1_breq),
    .m2_breq   (m2_breq),
    .m1_bgrant (m1_bgrant),
    .m2_bgrant (m2_bgrant),
    .m1_mvalid (m1_mvalid),
    .m2_mvalid (m2_mvalid),
    .m1_mode   (m1_mode),
    .m2_mode   (m2_mode),
    .svalid    (svalid),
    .msel      (msel),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive n consecutive serial bits from master m (0 = m1, 1 = m2).
  task automatic send(input logic m, input int n);
    for (int i = 0; i < n; i++) begin
      if (m) m2_mvalid = 1'b1;
      else   m1_mvalid = 1'b1;
      tick();
    end
    m1_mvalid = 1'b0;
    m2_mvalid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_g1", {31'd0, m1_bgrant}, 32'd0);
    check("rst_g2", {31'd0, m2_bgrant}, 32'd0);
    check("rst_msel", {31'd0, msel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tmo", {31'd0, timeout}, 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: m1 write, mode changes after first bit must not matter
    m1_breq = 1'b1; m1_mode = 1'b1;
    tick();                                   // cycle 1
    check("t1_grant_lat", {31'd0, m1_bgrant}, 32'd1);
    check("t1_msel", {31'd0, msel}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();                                   // cycle 2
    for (int i = 0; i < 20; i++) begin
      check("t1_grant_held", {31'd0, m1_bgrant}, 32'd1);
      m1_mvalid = 1'b1;
      m1_mode = (i == 0) ? 1'b1 : 1'b0;
      if (i == 19) m1_breq = 1'b0;
      tick();
    end
    m1_mvalid = 1'b0;                         // cycle 22
    check("t1_grant_drop", {31'd0, m1_bgrant}, 32'd0);
    check("t1_busy_rel", {31'd0, busy}, 32'd1);
    check("t1_no_tmo", {31'd0, timeout}, 32'd0);
    tick();                                   // cycle 23
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // Test 2: tie after reset -> m1, then alternation
    rst = 1'b1; tick(); rst = 1'b0;
    m1_breq = 1'b1; m2_breq = 1'b1; m1_mode = 1'b1; m2_mode = 1'b1;
    tick();
    check("t2_tie_g1", {31'd0, m1_bgrant}, 32'd1);
    check("t2_tie_g2", {31'd0, m2_bgrant}, 32'd0);
    send(1'b0, 20);
    check("t2_rel1_g1", {31'd0, m1_bgrant}, 32'd0);
    check("t2_rel1_g2", {31'd0, m2_bgrant}, 32'd0);
    tick();
    check("t2_turn_g2", {31'd0, m2_bgrant}, 32'd0);
    tick();
    check("t2_alt_g2", {31'd0, m2_bgrant}, 32'd1);
    check("t2_alt_g1", {31'd0, m1_bgrant}, 32'd0);
    check("t2_alt_msel", {31'd0, msel}, 32'd1);
    send(1'b1, 20);
    check("t2_rel2_g2", {31'd0, m2_bgrant}, 32'd0);
    tick(); tick();
    check("t2_back_g1", {31'd0, m1_bgrant}, 32'd1);
    check("t2_back_msel", {31'd0, msel}, 32'd0);
    m1_breq = 1'b0; m2_breq = 1'b0;
    tick();
    check("t2_drop_g1", {31'd0, m1_bgrant}, 32'd0);
    check("t2_drop_tmo", {31'd0, timeout}, 32'd0);
    check("t2_drop_busy", {31'd0, busy}, 32'd1);
    tick();

    // Test 3: m2 read with gapped svalid
    m2_breq = 1'b1; m2_mode = 1'b0;
    tick();
    check("t3_grant", {31'd0, m2_bgrant}, 32'd1);
    check("t3_msel", {31'd0, msel}, 32'd1);
    send(1'b1, 12);
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < 3; g++) begin
        check("t3_gap_grant", {31'd0, m2_bgrant}, 32'd1);
        check("t3_gap_msel", {31'd0, msel}, 32'd1);
        tick();
      end
      check("t3_bit_grant", {31'd0, m2_bgrant}, 32'd1);
      svalid = 1'b1;
      tick();
      svalid = 1'b0;
    end
    check("t3_rel_grant", {31'd0, m2_bgrant}, 32'd0);
    check("t3_rel_tmo", {31'd0, timeout}, 32'd0);
    m2_breq = 1'b0;
    tick();

    // Test 4: 5 address bits then silence -> timeout
    m1_breq = 1'b1; m1_mode = 1'b1;
    tick();
    check("t4_grant", {31'd0, m1_bgrant}, 32'd1);
    send(1'b0, 5);
    m1_breq = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    check("t4_pre_tmo", {31'd0, timeout}, 32'd0);
    check("t4_pre_grant", {31'd0, m1_bgrant}, 32'd1);
    tick();
    check("t4_tmo", {31'd0, timeout}, 32'd1);
    check("t4_tmo_grant", {31'd0, m1_bgrant}, 32'd0);
    check("t4_tmo_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t4_tmo_pulse", {31'd0, timeout}, 32'd0);
    check("t4_idle_busy", {31'd0, busy}, 32'd0);

    // Test 5: m2 mvalid during m1's transaction is ignored
    m1_breq = 1'b1; m1_mode = 1'b1;
    tick();
    check("t5_grant", {31'd0, m1_bgrant}, 32'd1);
    m2_mvalid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    m1_mvalid = 1'b1;
    for (int i = 0; i < 19; i++) tick();
    m1_mvalid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t5_held_g1", {31'd0, m1_bgrant}, 32'd1);
    check("t5_held_g2", {31'd0, m2_bgrant}, 32'd0);
    m2_mvalid = 1'b0;
    m1_mvalid = 1'b1;
    tick();
    m1_mvalid = 1'b0;
    check("t5_rel", {31'd0, m1_bgrant}, 32'd0);
    m1_breq = 1'b0;
    tick();

    // Test 6: reset in the middle of write data
    m1_breq = 1'b1;
    tick();
    send(1'b0, 14);
    check("t6_pre_grant", {31'd0, m1_bgrant}, 32'd1);
    rst = 1'b1; m1_breq = 1'b0; m2_breq = 1'b1;
    tick();
    check("t6_rst_g1", {31'd0, m1_bgrant}, 32'd0);
    check("t6_rst_g2", {31'd0, m2_bgrant}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_msel", {31'd0, msel}, 32'd0);
    rst = 1'b0;
    tick();
    check("t6_regrant", {31'd0, m2_bgrant}, 32'd1);
    check("t6_regrant_msel", {31'd0, msel}, 32'd1);
    m2_breq = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
